newton_multiply: RTL and testbench

//  Final stage of one Newton-Raphson iteration of the fast inverse square root

---
 rtl/fisr_pkg.sv | 24 ++
 rtl/newton_multiply_if.sv | 22 ++
 rtl/fp_mant_mul.sv | 13 +
 rtl/newton_multiply.sv | 137 +++++++++++++
 tb/tb_newton_multiply.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fisr_pkg.sv
// rtl/fisr_pkg.sv - shared FP32 constants for the fast inverse square root pipeline
// Field positions, exponent bias and the two well-known constants of the
// algorithm, plus a field view of an FP32 word.
package fisr_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] ONE_AND_HALF = 32'h3FC00000;
    localparam logic [31:0] MAGIC        = 32'h5F3759DF;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/newton_multiply_if.sv
// rtl/newton_multiply_if.sv - operand/result bundle for the Newton multiply stage
// master : drives ce, NumA, Init; receives NumOut, ce_out
// slave  : the multiply stage itself
interface newton_multiply_if #(
    parameter int W = 32
);
    logic         ce;
    logic [W-1:0] NumA;
    logic [W-1:0] Init;
    logic [W-1:0] NumOut;
    logic         ce_out;

    modport master (
        output ce, NumA, Init,
        input  NumOut, ce_out
    );

    modport slave (
        input  ce, NumA, Init,
        output NumOut, ce_out
    );
endinterface

// File: rtl/fp_mant_mul.sv
// rtl/fp_mant_mul.sv - combinational unsigned significand multiplier
// a, b : W-bit significands with hidden bit
// p    : 2W-bit full product
// Kept as its own module so synthesis can map it onto DSP blocks.
module fp_mant_mul #(
    parameter int W = 24
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    assign p = a * b;
endmodule

// File: rtl/newton_multiply.sv
// rtl/newton_multiply.sv - final Newton-Raphson multiply y1 = NumA * Init (FP32, truncating)
// clk    : clock, all state on posedge
// rst    : synchronous active-high reset, clears NumOut, ce_out and stage valids
// bus    : slave side of newton_multiply_if
//          ce/NumA/Init in, NumOut/ce_out out, three-cycle fixed latency
module newton_multiply
    import fisr_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int BIAS  = FP_BIAS
) (
    input  logic           clk,
    input  logic           rst,
    newton_multiply_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 1;
    localparam int PW  = 2 * MW;
    // Two extra bits so the sum of two biased exponents minus bias is
    // representable as a signed value (range -BIAS .. 2*max-BIAS+1).
    localparam int EW2 = EXP_W + 2;

    localparam logic [EW2-1:0] BIAS_X  = EW2'(BIAS);
    localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    // ---------------- operand fields ----------------
    logic             a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [PW-1:0]    prod;

    assign a_sign = bus.NumA[W-1];
    assign b_sign = bus.Init[W-1];
    assign a_exp  = bus.NumA[W-2 -: EXP_W];
    assign b_exp  = bus.Init[W-2 -: EXP_W];
    assign a_man  = bus.NumA[MAN_W-1:0];
    assign b_man  = bus.Init[MAN_W-1:0];

    fp_mant_mul #(.W(MW)) u_mant_mul (
        .a ({1'b1, a_man}),
        .b ({1'b1, b_man}),
        .p (prod)
    );

    // ---------------- stage 1: capture and multiply ----------------
    logic             v1;
    logic             s1_sign;
    logic [EW2-1:0]   s1_exp;
    logic [PW-1:0]    s1_prod;
    logic             s1_zero;
    logic             s1_inf;

    always_ff @(posedge clk) begin
        if (rst) v1 <= 1'b0;
        else     v1 <= bus.ce;
    end

    // Datapath registers need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_sign <= a_sign ^ b_sign;
        s1_exp  <= {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X;
        s1_prod <= prod;
        // Exponent field zero covers true zero and denormals alike.
        s1_zero <= (a_exp == '0) || (b_exp == '0);
        // All-ones exponent: inf and NaN are not told apart.
        s1_inf  <= (&a_exp) || (&b_exp);
    end

    // ---------------- stage 2: normalise ----------------
    logic             v2;
    logic             s2_sign;
    logic [EW2-1:0]   s2_exp;
    logic [MAN_W-1:0] s2_mant;
    logic             s2_zero;
    logic             s2_inf;
    logic             unused_prod_lsbs;

    // Product of two [1,2) significands lies in [1,4): only the top bit
    // decides a one-place shift. Bits below the kept field are truncated.
    assign unused_prod_lsbs = ^s1_prod[MAN_W-2:0];

    always_ff @(posedge clk) begin
        if (rst) v2 <= 1'b0;
        else     v2 <= v1;
    end

    always_ff @(posedge clk) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_inf  <= s1_inf;
        if (s1_prod[PW-1]) begin
            s2_mant <= s1_prod[PW-2 -: MAN_W];
            s2_exp  <= s1_exp + EW2'(1);
        end else begin
            s2_mant <= s1_prod[PW-3 -: MAN_W];
            s2_exp  <= s1_exp;
        end
    end

    // ---------------- stage 3: pack and exceptions ----------------
    logic         v3;
    logic [W-1:0] num_out_q;
    logic [W-1:0] packed_res;
    logic         exp_under;
    logic         exp_over;

    // s2_exp is two's complement: MSB set means negative.
    assign exp_under = s2_exp[EW2-1] || (s2_exp == '0);
    assign exp_over  = !s2_exp[EW2-1] && (s2_exp >= EXP_MAX);

    always_comb begin
        packed_res = {s2_sign, s2_exp[EXP_W-1:0], s2_mant};
        // Zero wins over inf, so 0 x inf yields a signed zero.
        if (s2_zero || exp_under) begin
            packed_res = {s2_sign, {(W-1){1'b0}}};
        end else if (s2_inf || exp_over) begin
            packed_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // NumOut only changes when a valid result enters the last stage,
    // so it holds between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3        <= 1'b0;
            num_out_q <= '0;
        end else begin
            v3 <= v2;
            if (v2) num_out_q <= packed_res;
        end
    end

    assign bus.NumOut = num_out_q;
    assign bus.ce_out = v3;

endmodule

// File: tb/tb_newton_multiply.sv
// tb/tb_newton_multiply.sv - self-checking bench for newton_multiply
module tb_newton_multiply;

    logic clk = 1'b0;
    logic rst;

    newton_multiply_if bus ();

    newton_multiply dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        logic [31:0] val;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic        exp_v;
    logic [31:0] exp_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @edge %0d: got=%h expected=%h", tag, edge_n, got, want);
        end
    endtask

    // Truncating FP32 multiply computed directly from the numeric rules.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e;
        longint      ma, mb, p;
        logic        s;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0)     return {s, 31'b0};
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0};
        ma = (longint'(1) << 23) + longint'(a[22:0]);
        mb = (longint'(1) << 23) + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            p = p >> 1;
            e = e + 1;
        end
        m = 23'(p >> 23);
        if (e <= 0)   return {s, 31'b0};
        if (e >= 255) return {s, 8'hFF, 23'b0};
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(1, 254));
        else                           e = 8'($urandom_range(64, 190));
        return {r[31], e, r[22:0]};
    endfunction

    // One clock: drive inputs just after an edge, let the next edge consume
    // them, update the expected outputs, then compare 1 ns after that edge.
    // A result sampled at edge k must appear after edge k+2.
    task automatic cycle(input logic c, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic use_exp, input logic [31:0] expv);
        rst      = r;
        bus.ce   = c;
        bus.NumA = a;
        bus.Init = b;
        @(posedge clk);
        edge_n++;
        if (r) begin
            pend.delete();
            exp_v = 1'b0;
            exp_o = 32'h0;
        end else begin
            if (c) pend.push_back('{use_exp ? expv : ref_mul(a, b), edge_n + 2});
            exp_v = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_o = pend[0].val;
                exp_v = 1'b1;
                void'(pend.pop_front());
            end
        end
        #1;
        check("ce_out", {31'b0, bus.ce_out}, {31'b0, exp_v});
        check("NumOut", bus.NumOut, exp_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic op_known(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        cycle(1'b1, a, b, 1'b0, 1'b1, expv);
    endtask

    task automatic op_rand();
        cycle(1'b1, rand_fp(), rand_fp(), 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        bus.ce   = 1'b0;
        bus.NumA = 32'h0;
        bus.Init = 32'h0;
        exp_v    = 1'b0;
        exp_o    = 32'h0;

        // Reset, with ce asserted during the reset cycle (must be ignored).
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 32'h3FC00000, 32'h3FC00000, 1'b1, 1'b0, 32'h0);

        // First cycle after reset is accepted; 1.5 * 1.0.
        op_known(32'h3FC00000, 32'h3F800000, 32'h3FC00000);
        idle(4);

        // Normalise-shift path, zero, sign, overflow, underflow, 0 x inf.
        op_known(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        idle(3);
        op_known(32'h00000000, 32'h5F3759DF, 32'h00000000);
        op_known(32'h3F800000, 32'hBF800000, 32'hBF800000);
        op_known(32'h7F000000, 32'h40000000, 32'h7F800000);
        op_known(32'h00800000, 32'h00800000, 32'h00000000);
        op_known(32'h80000000, 32'h7F800000, 32'h80000000);
        op_known(32'hFF800000, 32'h3F800000, 32'hFF800000);
        idle(4);

        // Ten back-to-back random operations.
        for (int i = 0; i < 10; i++) op_rand();
        idle(4);

        // Random mix of operations and gaps; NumOut must hold across gaps.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) op_rand();
            else                           idle(1);
        end
        idle(4);

        // Two operations in flight, then a one-cycle reset flushes them.
        op_rand();
        op_rand();
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(5);

        // Fresh operation after the flush.
        op_known(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
